// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: memory-stage results in, register-file write port and
// debug state out. The master side drives the stage, the slave side is the stage.
interface mem_wb_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  // Pipeline control
  logic                  stall;
  logic                  flush;
  // Memory-stage results
  logic                  in_valid;
  logic                  in_reg_write;
  logic                  in_mem_to_reg;
  logic [2:0]            in_funct3;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [XLEN-1:0]       in_alu_result;
  logic [XLEN-1:0]       in_mem_data;
  // Writeback outputs
  logic                  wb_valid;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [63:0]           retire_count;
  logic                  misaligned_fault;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_funct3,
           in_rd, in_alu_result, in_mem_data,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, retire_count, misaligned_fault
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_funct3,
           in_rd, in_alu_result, in_mem_data,
    output wb_valid, wb_reg_write, wb_rd, wb_data, retire_count, misaligned_fault
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback logic: load width selection with
// sign/zero extension, load alignment check, register-file write port,
// retired-instruction counter and sticky misaligned-load flag.
module mem_wb_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);

  // Misalignment of a load with the given funct3 at byte offset a[2:0].
  // funct3[1:0] encodes the access size; 11 covers both LD and the reserved code.
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [2:0] a);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      2'b10:   mis = |a[1:0];
      default: mis = |a;
    endcase
    return mis;
  endfunction

  // MEM/WB pipeline register fields
  logic                  r_valid;
  logic                  r_reg_write;
  logic                  r_mem_to_reg;
  logic [2:0]            r_funct3;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_mem_data;
  logic [63:0]           r_retire_count;
  logic                  r_misaligned_fault;

  logic                  w_misaligned;
  logic                  w_in_misaligned;
  logic                  w_capture;
  logic [XLEN-1:0]       w_load_data;

  // Alignment of the registered instruction and of the one being captured
  assign w_misaligned    = r_valid && r_mem_to_reg &&
                           load_misaligned(r_funct3, r_alu_result[2:0]);
  assign w_in_misaligned = bus.in_mem_to_reg &&
                           load_misaligned(bus.in_funct3, bus.in_alu_result[2:0]);
  assign w_capture       = !bus.flush && !bus.stall;

  // Load extraction from the registered data word
  always_comb begin
    w_load_data = r_mem_data;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){r_mem_data[7]}},   r_mem_data[7:0]};
      3'b001:  w_load_data = {{(XLEN-16){r_mem_data[15]}}, r_mem_data[15:0]};
      3'b010:  w_load_data = {{(XLEN-32){r_mem_data[31]}}, r_mem_data[31:0]};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}},  r_mem_data[7:0]};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, r_mem_data[15:0]};
      3'b110:  w_load_data = {{(XLEN-32){1'b0}}, r_mem_data[31:0]};
      default: w_load_data = r_mem_data;
    endcase
  end

  // Pipeline register: flush inserts a bubble (beats stall), stall holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.flush) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
    end else if (!bus.stall) begin
      r_valid      <= bus.in_valid;
      r_reg_write  <= bus.in_reg_write;
      r_mem_to_reg <= bus.in_mem_to_reg;
      r_funct3     <= bus.in_funct3;
      r_rd         <= bus.in_rd;
      r_alu_result <= bus.in_alu_result;
      r_mem_data   <= bus.in_mem_data;
    end
  end

  // Count each valid, aligned instruction once, on the edge that captures it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_count <= '0;
    end else if (w_capture && bus.in_valid && !w_in_misaligned) begin
      r_retire_count <= r_retire_count + 64'd1;
    end
  end

  // Sticky fault: set one edge after a misaligned load sits in the register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misaligned_fault <= 1'b0;
    end else if (w_misaligned) begin
      r_misaligned_fault <= 1'b1;
    end
  end

  assign bus.wb_valid         = r_valid;
  assign bus.wb_reg_write     = r_valid && r_reg_write && (r_rd != '0) && !w_misaligned;
  assign bus.wb_rd            = r_rd;
  assign bus.wb_data          = !r_valid     ? '0 :
                                r_mem_to_reg ? w_load_data : r_alu_result;
  assign bus.retire_count     = r_retire_count;
  assign bus.misaligned_fault = r_misaligned_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed test-plan sequences followed by random
// traffic, checked by a scoreboard fed from a behavioural reference model.
module tb_mem_wb_stage;

  logic clk;
  logic reset;

  mem_wb_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

  mem_wb_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference-model state: the instruction currently held in MEM/WB
  typedef struct {
    bit              valid;
    bit              rw;
    bit              m2r;
    bit [2:0]        f3;
    bit [4:0]        rd;
    longint unsigned alu;
    longint unsigned mem;
  } mreg_t;

  typedef struct {
    bit              valid;
    bit              rw;
    bit [4:0]        rd;
    longint unsigned data;
    longint unsigned cnt;
    bit              fault;
  } exp_t;

  mreg_t           m;
  longint unsigned m_cnt;
  bit              m_fault;
  exp_t            q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, req, $time);
    end
  endtask

  // Access size in bytes from funct3 (reserved 111 behaves as a doubleword)
  function automatic int unsigned size_of(input bit [2:0] f3);
    return (f3[1:0] == 2'b11) ? 8 : (1 << f3[1:0]);
  endfunction

  function automatic bit ref_misaligned(input bit [2:0] f3, input longint unsigned addr);
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic longint unsigned ref_load(input bit [2:0] f3, input longint unsigned d);
    int unsigned     bits;
    longint unsigned mask;
    longint unsigned v;
    bits = 8 * size_of(f3);
    mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    v = d & mask;
    if (!f3[2] && bits < 64 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    bit   mis;
    mis     = m.valid && m.m2r && ref_misaligned(m.f3, m.alu);
    e.valid = m.valid;
    e.rd    = m.rd;
    e.rw    = m.valid && m.rw && (m.rd != 0) && !mis;
    e.data  = !m.valid ? 64'd0 : (m.m2r ? ref_load(m.f3, m.mem) : m.alu);
    e.cnt   = m_cnt;
    e.fault = m_fault;
    return e;
  endfunction

  task automatic model_reset();
    m       = '{default: 0};
    m_cnt   = 0;
    m_fault = 0;
  endtask

  // One clock edge of the reference model, using the inputs held across it
  task automatic model_edge();
    if (m.valid && m.m2r && ref_misaligned(m.f3, m.alu)) m_fault = 1;
    if (bus.flush) begin
      m = '{default: 0};
    end else if (!bus.stall) begin
      if (bus.in_valid && !(bus.in_mem_to_reg && ref_misaligned(bus.in_funct3, bus.in_alu_result)))
        m_cnt = m_cnt + 1;
      m.valid = bus.in_valid;
      m.rw    = bus.in_reg_write;
      m.m2r   = bus.in_mem_to_reg;
      m.f3    = bus.in_funct3;
      m.rd    = bus.in_rd;
      m.alu   = bus.in_alu_result;
      m.mem   = bus.in_mem_data;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, record the expected outputs
  task automatic apply(input bit st, input bit fl, input bit v, input bit rw, input bit m2r,
                       input bit [2:0] f3, input bit [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] mem);
    bus.stall         = st;
    bus.flush         = fl;
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_to_reg = m2r;
    bus.in_funct3     = f3;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
    bus.in_mem_data   = mem;
    @(posedge clk);
    #1;
    model_edge();
    q.push_back(model_outputs());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {63'd0, bus.wb_valid}, 64'd0);
    chk({tag, "_rw"},    {63'd0, bus.wb_reg_write}, 64'd0);
    chk({tag, "_rd"},    {59'd0, bus.wb_rd}, 64'd0);
    chk({tag, "_data"},  bus.wb_data, 64'd0);
    chk({tag, "_cnt"},   bus.retire_count, 64'd0);
    chk({tag, "_fault"}, {63'd0, bus.misaligned_fault}, 64'd0);
  endtask

  // Monitor: compare every registered cycle against the scoreboard
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_valid", {63'd0, bus.wb_valid}, {63'd0, e.valid});
      chk("sb_rw",    {63'd0, bus.wb_reg_write}, {63'd0, e.rw});
      chk("sb_rd",    {59'd0, bus.wb_rd}, {59'd0, e.rd});
      chk("sb_data",  bus.wb_data, e.data);
      chk("sb_cnt",   bus.retire_count, e.cnt);
      chk("sb_fault", {63'd0, bus.misaligned_fault}, {63'd0, e.fault});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rm;
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_mem_to_reg = 1'b0;
    bus.in_funct3     = 3'd0;
    bus.in_rd         = 5'd0;
    bus.in_alu_result = 64'd0;
    bus.in_mem_data   = 64'd0;
    model_reset();
    #3;
    check_all_zero("reset");
    do_reset();

    // 1: LB sign extension
    apply(0, 0, 1, 1, 1, 3'b000, 5'd5, 64'h100, 64'h0000_0000_0000_00F0);
    $display("LB  rd=5 -> wb_data=0x%h cnt=%0d", bus.wb_data, bus.retire_count);
    chk("t1_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("t1_rd",   {59'd0, bus.wb_rd}, 64'd5);
    chk("t1_rw",   {63'd0, bus.wb_reg_write}, 64'd1);
    chk("t1_cnt",  bus.retire_count, 64'd1);

    // 2: LHU aligned, then misaligned LW
    apply(0, 0, 1, 1, 1, 3'b101, 5'd6, 64'h102, 64'h1234_5678_9ABC_8001);
    $display("LHU rd=6 -> wb_data=0x%h cnt=%0d", bus.wb_data, bus.retire_count);
    chk("t2_lhu_data", bus.wb_data, 64'h8001);
    apply(0, 0, 1, 1, 1, 3'b010, 5'd6, 64'h102, 64'h1234_5678_9ABC_8001);
    $display("LW  misaligned -> wb_rw=%0b fault=%0b cnt=%0d",
             bus.wb_reg_write, bus.misaligned_fault, bus.retire_count);
    chk("t2_lw_rw",    {63'd0, bus.wb_reg_write}, 64'd0);
    chk("t2_lw_cnt",   bus.retire_count, 64'd2);
    apply(0, 0, 0, 0, 0, 3'b000, 5'd0, 64'h0, 64'h0);
    $display("bubble -> fault=%0b", bus.misaligned_fault);
    chk("t2_fault",    {63'd0, bus.misaligned_fault}, 64'd1);

    // 3: ALU op targeting x0
    apply(0, 0, 1, 1, 0, 3'b000, 5'd0, 64'h1234, 64'hDEAD);
    $display("ALU rd=0 -> wb_data=0x%h rw=%0b cnt=%0d",
             bus.wb_data, bus.wb_reg_write, bus.retire_count);
    chk("t3_data", bus.wb_data, 64'h1234);
    chk("t3_rw",   {63'd0, bus.wb_reg_write}, 64'd0);
    chk("t3_cnt",  bus.retire_count, 64'd3);

    // 4: ADD rd=7 then 3 stall cycles with changing inputs
    apply(0, 0, 1, 1, 0, 3'b000, 5'd7, 64'h77, 64'h0);
    $display("ADD rd=7 -> wb_data=0x%h cnt=%0d", bus.wb_data, bus.retire_count);
    for (int i = 0; i < 3; i++) begin
      ra = {$urandom, $urandom};
      rm = {$urandom, $urandom};
      apply(1, 0, 1, 1, 1, 3'($urandom_range(0, 7)), 5'($urandom_range(1, 31)), ra, rm);
      $display("stall %0d -> wb_rd=%0d wb_data=0x%h cnt=%0d",
               i, bus.wb_rd, bus.wb_data, bus.retire_count);
      chk("t4_rd",   {59'd0, bus.wb_rd}, 64'd7);
      chk("t4_data", bus.wb_data, 64'h77);
      chk("t4_cnt",  bus.retire_count, 64'd4);
    end

    // 5: flush + stall with a valid input, then asynchronous reset mid-cycle
    apply(1, 1, 1, 1, 0, 3'b000, 5'd9, 64'h99, 64'h0);
    $display("flush+stall -> wb_valid=%0b wb_data=0x%h cnt=%0d",
             bus.wb_valid, bus.wb_data, bus.retire_count);
    chk("t5_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("t5_data",  bus.wb_data, 64'd0);
    chk("t5_cnt",   bus.retire_count, 64'd4);
    apply(0, 0, 1, 1, 0, 3'b000, 5'd9, 64'h99, 64'h0);
    #2;
    reset = 1'b1;
    q.delete();
    model_reset();
    #1;
    $display("async reset mid-cycle -> wb_valid=%0b cnt=%0d fault=%0b",
             bus.wb_valid, bus.retire_count, bus.misaligned_fault);
    check_all_zero("t5_async");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 6: counter wrap via deposit
    dut.r_retire_count = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    apply(0, 0, 1, 1, 0, 3'b000, 5'd3, 64'h5, 64'h0);
    $display("wrap -> cnt=%0d", bus.retire_count);
    chk("t6_wrap", bus.retire_count, 64'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 450; i++) begin
      if (i % 150 == 149) do_reset();
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) ra[2:0] = 3'b000;
      rm = {$urandom, $urandom};
      apply($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) < 3, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), ra, rm);
      $display("rand %0d: wb_valid=%0b rw=%0b rd=%0d data=0x%h cnt=%0d fault=%0b",
               i, bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.wb_data,
               bus.retire_count, bus.misaligned_fault);
    end

    @(posedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Writeback-side neighbour of the memory access stage, with an internal MEM/WB pipeline register.
- Captures the memory-stage results: ALU result, raw load data and control.
- Performs load-width selection with sign or zero extension, checks load alignment, and drives the register-file write port.
- Keeps a retired-instruction counter and a sticky misaligned-load fault flag for the bench and debug $display output.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the MEM/WB register contents.
- flush  in  1  load a bubble into the MEM/WB register.
- in_valid  in  1  the memory stage holds a real instruction.
- in_reg_write  in  1  the instruction writes rd.
- in_mem_to_reg  in  1  1 = load result, 0 = ALU result.
- in_funct3  in  3  load width/sign code.
- in_rd  in  REG_ADDR_W  destination register.
- in_alu_result  in  XLEN  ALU result, which is also the effective address.
- in_mem_data  in  XLEN  data-memory read data; byte 0 is the byte at the effective address.
- wb_valid  out  1  the registered instruction is valid.
- wb_reg_write  out  1  register-file write enable.
- wb_rd  out  REG_ADDR_W  register-file write index.
- wb_data  out  XLEN  register-file write data.
- retire_count  out  64  count of retired valid instructions.
- misaligned_fault  out  1  sticky; set by any misaligned load.

Behaviour:
- Reset (asynchronous, active-high): clears all MEM/WB fields, retire_count and misaligned_fault. During and after reset: wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, retire_count=0, misaligned_fault=0.
- Register update priority at each posedge, highest first:
  - reset.
  - flush: capture a bubble. valid=0; all other fields 0. Flush wins over stall.
  - stall: hold all fields.
  - otherwise: capture all in_* fields.
- Latency: one cycle. An instruction presented in cycle N appears on wb_* in cycle N+1. wb_* outputs are combinational from registered fields only; no input reaches an output combinationally.
- Load extraction, from registered mem_data (d) by registered funct3:
  - 000 LB: sign-extend d[7:0].
  - 001 LH: sign-extend d[15:0].
  - 010 LW: sign-extend d[31:0].
  - 011 LD: d.
  - 100 LBU: zero-extend d[7:0].
  - 101 LHU: zero-extend d[15:0].
  - 110 LWU: zero-extend d[31:0].
  - 111: reserved, treated as LD.
- wb_data = mem_to_reg ? extracted load : alu_result. When the registered valid is 0, wb_data=0.
- Misalignment, evaluated on the registered instruction only when valid && mem_to_reg, using a = alu_result:
  - LH/LHU misaligned if a[0]≠0.
  - LW/LWU misaligned if a[1:0]≠0.
  - LD/111 misaligned if a[2:0]≠0.
  - LB/LBU never misaligned.
- Effect of a misaligned load:
  - wb_reg_write is forced to 0 for that instruction.
  - misaligned_fault is set at the next posedge and stays set until reset.
  - The instruction does not count as retired.
- wb_reg_write = valid && reg_write && (rd≠0) && !misaligned. Writes to x0 are always suppressed.
- retire_count increments by 1 at each posedge that captures a new instruction that is valid and not misaligned (no reset, flush or stall that edge). Misalignment is computed from the in_* values for this purpose. A held (stalled) instruction is never counted twice. The counter wraps from 2^64−1 to 0.
- Simultaneous flush and stall: bubble inserted; retire_count unchanged.
- Reset asserted mid-stall or mid-fault: everything is cleared immediately, without waiting for a clock edge.

Test Plan:
1. Reset, then LB with in_mem_data=0x00000000000000F0, addr=0x100, rd=5, mem_to_reg=1, reg_write=1 → next cycle wb_data=0xFFFFFFFFFFFFFFF0, wb_rd=5, wb_reg_write=1, retire_count=1.
2. LHU, mem_data=0x...8001, addr=0x102 → wb_data=0x8001. Then LW at addr=0x102 → wb_reg_write=0, misaligned_fault=1 from the following edge, retire_count unchanged.
3. ALU op, alu_result=0x1234, mem_to_reg=0, rd=0 → wb_data=0x1234, wb_reg_write=0 (x0), retire_count still increments.
4. Capture ADD rd=7, then stall for 3 cycles while the inputs change → wb_rd=7 and wb_data held for all 3 cycles; retire_count increments exactly once.
5. flush and stall together, with a valid input → wb_valid=0, wb_data=0, retire_count unchanged. Assert reset asynchronously mid-cycle → all outputs 0 before the next posedge.
6. Force retire_count to 0xFFFFFFFFFFFFFFFF via hierarchical deposit, then retire one instruction → retire_count=0.
